if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Instruction-fetch front end and IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC and issues requests to instruction memory using a req/ack handshake with variable latency.
- Presents {instruction, PC+4, valid} to ID.
- Directly consumes the load-use stall from the hazard detection unit and the branch/jump flush and redirect from ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word driven on a bubble (sll $0,$0,0).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- stall_i  in  1  load-use stall from hazard detection; holds the IF/ID register.
- flush_i  in  1  branch taken or jump resolved in ID; squashes fetch.
- redirect_pc_i  in  32  target PC, valid when flush_i=1.
- imem_req_o  out  1  instruction memory request.
- imem_addr_o  out  32  word address (PC); held stable while imem_req_o=1 and ack has not arrived.
- imem_ack_i  in  1  memory returns data this cycle; only meaningful while imem_req_o=1.
- imem_data_i  in  32  instruction word, valid with imem_ack_i.
- ifid_inst_o  out  32  IF/ID instruction.
- ifid_pc4_o  out  32  IF/ID PC+4.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- fetch_busy_o  out  1  1 when state is DRAIN or HOLD.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - pc=RESET_PC, state=FETCH.
  - ifid_inst_o=NOP_INST, ifid_pc4_o=0, ifid_valid_o=0.
  - Skid buffer cleared.
  - imem_req_o=0 during the reset cycle; asserts the cycle after reset deasserts.
  - Reset overrides all other inputs, including mid-transaction; any outstanding ack is ignored.
- State FETCH:
  - imem_req_o=1, imem_addr_o=pc.
  - ack & !stall & !flush: IF/ID <= {imem_data_i, pc+4, 1}; pc<=pc+4; stay in FETCH. Zero-wait memory gives 1 instruction/cycle.
  - ack & stall & !flush: skid <= {imem_data_i, pc+4}; IF/ID unchanged; goto HOLD.
  - !ack & !stall & !flush: IF/ID <= bubble (NOP_INST, valid=0; pc4 don't-care, drive 0).
  - !ack & stall: IF/ID unchanged.
  - flush & ack: discard data; IF/ID <= bubble; pc<=redirect_pc_i; stay in FETCH.
  - flush & !ack: IF/ID <= bubble; pc<=redirect_pc_i; goto DRAIN. The old address stays on the bus until ack.
- State DRAIN:
  - imem_req_o=1, imem_addr_o = old address, held in a separate register.
  - On ack: discard data; goto FETCH, which uses the redirected pc.
  - A further flush in DRAIN overwrites pc with the new redirect_pc_i.
  - IF/ID follows the stall/bubble rules with no new data.
- State HOLD:
  - imem_req_o=0.
  - !stall: IF/ID <= {skid, valid=1}; pc<=pc+4; goto FETCH.
  - flush: discard skid; IF/ID <= bubble; pc<=redirect_pc_i; goto FETCH.
- Priority: rst_i > flush_i > stall_i.
  - flush with stall both asserted: flush wins and IF/ID is bubbled.
- Latency: ack at edge N → ifid_* valid after edge N.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- redirect_pc_i[1:0] is ignored and forced to 00.
- Outputs are registered except imem_req_o and imem_addr_o, which are decoded from state and registers only. No combinational path from any input to any output.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o counts cycles with stall_i=1 (outside reset).
  - flush_cnt_o counts cycles with flush_i=1.
  - Both saturate at 32'hFFFF_FFFF and are cleared by rst_i.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Zero-wait stream: ack tied to req, imem_data=addr^32'hA5A5_0000, 4 cycles after reset → ifid_pc4_o = 4, 8, 12, 16 on consecutive cycles, valid=1, inst matches.
- 2-cycle latency memory, no stall → one valid instruction every 3 cycles with bubbles (NOP, valid=0) between; imem_addr_o stable during each wait.
- Load-use stall: ack at PC=0x10 with stall_i=1 for 2 cycles → IF/ID holds the previous instruction, imem_req_o=0; after stall drops, IF/ID = inst@0x10, pc4=0x14, next req addr=0x14.
- Flush during wait: req at 0x20 pending, flush_i=1 with redirect 0x100 → IF/ID bubble, fetch_busy_o=1, addr stays 0x20 until ack; next req addr=0x100 and data for 0x20 never appears in IF/ID.
- Flush+stall same cycle in HOLD with redirect 0x40 → skid discarded, IF/ID bubble, next req addr=0x40.
- Reset mid-wait at pc=0x30 with ack arriving during reset → pc=RESET_PC, valid=0, req resumes at 0x0; counters (if IF_PERF_CNT_EN) read 0.

Source files
------------

// File: rtl/if_id_stage.sv
// Instruction fetch front end and IF/ID pipeline register for the 5-stage MIPS core.
// Optional IF_PERF_CNT_EN macro adds saturating stall/flush cycle counters.
module if_id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] ifid_inst_o,
   output logic [31:0] ifid_pc4_o,
   output logic        ifid_valid_o,
   output logic        fetch_busy_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  drain_addr_q, drain_addr_d;
   logic [31:0]  skid_inst_q, skid_inst_d;
   logic [31:0]  skid_pc4_q, skid_pc4_d;
   logic [31:0]  ifid_inst_q, ifid_inst_d;
   logic [31:0]  ifid_pc4_q, ifid_pc4_d;
   logic         ifid_valid_q, ifid_valid_d;
   logic         in_reset_q;
   logic         ack;
   logic [31:0]  pc_plus4;
   logic [31:0]  redirect_aligned;

   // in_reset_q keeps the request low for the cycle following a reset edge
   // without creating a path from rst_i to the memory interface.
   assign imem_req_o   = !in_reset_q && (state_q != HOLD);
   assign imem_addr_o  = (state_q == DRAIN) ? drain_addr_q : pc_q;
   assign fetch_busy_o = (state_q == DRAIN) || (state_q == HOLD);
   assign ifid_inst_o  = ifid_inst_q;
   assign ifid_pc4_o   = ifid_pc4_q;
   assign ifid_valid_o = ifid_valid_q;

   assign ack              = imem_ack_i && imem_req_o;
   assign pc_plus4         = pc_q + 32'd4;
   assign redirect_aligned = {redirect_pc_i[31:2], 2'b00};

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      skid_inst_d  = skid_inst_q;
      skid_pc4_d   = skid_pc4_q;
      ifid_inst_d  = ifid_inst_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;

      case (state_q)
         FETCH: begin
            if (flush_i) begin
               ifid_inst_d  = NOP_INST;
               ifid_pc4_d   = 32'd0;
               ifid_valid_d = 1'b0;
               pc_d         = redirect_aligned;
               // An unanswered request must complete before the new pc goes out.
               if (imem_req_o && !ack) begin
                  drain_addr_d = pc_q;
                  state_d      = DRAIN;
               end
            end else if (ack) begin
               if (stall_i) begin
                  skid_inst_d = imem_data_i;
                  skid_pc4_d  = pc_plus4;
                  state_d     = HOLD;
               end else begin
                  ifid_inst_d  = imem_data_i;
                  ifid_pc4_d   = pc_plus4;
                  ifid_valid_d = 1'b1;
                  pc_d         = pc_plus4;
               end
            end else if (!stall_i) begin
               ifid_inst_d  = NOP_INST;
               ifid_pc4_d   = 32'd0;
               ifid_valid_d = 1'b0;
            end
         end

         DRAIN: begin
            if (ack) begin
               state_d = FETCH;
            end
            if (flush_i) begin
               ifid_inst_d  = NOP_INST;
               ifid_pc4_d   = 32'd0;
               ifid_valid_d = 1'b0;
               pc_d         = redirect_aligned;
            end else if (!stall_i) begin
               ifid_inst_d  = NOP_INST;
               ifid_pc4_d   = 32'd0;
               ifid_valid_d = 1'b0;
            end
         end

         HOLD: begin
            if (flush_i) begin
               ifid_inst_d  = NOP_INST;
               ifid_pc4_d   = 32'd0;
               ifid_valid_d = 1'b0;
               pc_d         = redirect_aligned;
               state_d      = FETCH;
            end else if (!stall_i) begin
               ifid_inst_d  = skid_inst_q;
               ifid_pc4_d   = skid_pc4_q;
               ifid_valid_d = 1'b1;
               pc_d         = pc_plus4;
               state_d      = FETCH;
            end
         end

         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         skid_inst_q  <= NOP_INST;
         skid_pc4_q   <= 32'd0;
         ifid_inst_q  <= NOP_INST;
         ifid_pc4_q   <= 32'd0;
         ifid_valid_q <= 1'b0;
         in_reset_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         skid_inst_q  <= skid_inst_d;
         skid_pc4_q   <= skid_pc4_d;
         ifid_inst_q  <= ifid_inst_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
         in_reset_q   <= 1'b0;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // Saturating event counters; they stick at all-ones rather than wrap.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (flush_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed scenarios then random stall/flush/ack traffic,
// checked against a fetch-stream reference model.
module tb_if_id_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;
   logic [31:0] ifid_inst_o;
   logic [31:0] ifid_pc4_o;
   logic        ifid_valid_o;
   logic        fetch_busy_o;
`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: the next address the program wants, an optional
   // abandoned request still on the bus, and a queue of fetched-but-parked words.
   logic        m_started = 1'b0;
   logic        m_in_reset;
   logic [31:0] m_pc;
   logic        m_stale;
   logic [31:0] m_stale_addr;
   logic [63:0] q_skid[$];
   logic [31:0] m_inst;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic [31:0] m_stall_cnt;
   logic [31:0] m_flush_cnt;

   always #5 clk_i = ~clk_i;

   if_id_stage #(
      .RESET_PC(RESET_PC),
      .NOP_INST(NOP_INST)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .redirect_pc_i(redirect_pc_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_data_i  (imem_data_i),
      .ifid_inst_o  (ifid_inst_o),
      .ifid_pc4_o   (ifid_pc4_o),
      .ifid_valid_o (ifid_valid_o),
      .fetch_busy_o (fetch_busy_o)
`ifdef IF_PERF_CNT_EN
      ,
      .stall_cnt_o  (stall_cnt_o),
      .flush_cnt_o  (flush_cnt_o)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic logic exp_req();
      return !m_in_reset && (q_skid.size() == 0);
   endfunction

   function automatic logic [31:0] exp_addr();
      return m_stale ? m_stale_addr : m_pc;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelBubble();
      m_inst  = NOP_INST;
      m_pc4   = 32'd0;
      m_valid = 1'b0;
   endtask

   task automatic checkModel();
      checkOutput("req", 32'(imem_req_o), 32'(exp_req()));
      if (exp_req()) checkOutput("addr", imem_addr_o, exp_addr());
      checkOutput("inst", ifid_inst_o, m_inst);
      checkOutput("pc4", ifid_pc4_o, m_pc4);
      checkOutput("valid", 32'(ifid_valid_o), 32'(m_valid));
      checkOutput("busy", 32'(fetch_busy_o), 32'(m_stale || (q_skid.size() != 0)));
`ifdef IF_PERF_CNT_EN
      checkOutput("stall_cnt", stall_cnt_o, m_stall_cnt);
      checkOutput("flush_cnt", flush_cnt_o, m_flush_cnt);
`endif
   endtask

   // Drives one cycle of inputs from the negedge, advances the model at the
   // posedge, and compares everything at the following negedge.
   task automatic applyStimulus(input logic rst, input logic stall, input logic flush,
                                input logic [31:0] redir, input logic ack);
      logic        req_now;
      logic        ack_eff;
      logic [31:0] addr_now;
      req_now  = m_started ? exp_req() : 1'b0;
      addr_now = exp_addr();
      ack_eff  = ack && req_now;
      rst_i         = rst;
      stall_i       = stall;
      flush_i       = flush;
      redirect_pc_i = redir;
      imem_ack_i    = ack_eff;
      imem_data_i   = ack_eff ? mem_word(addr_now) : $urandom();
      @(posedge clk_i);
      if (rst) begin
         m_started   = 1'b1;
         m_in_reset  = 1'b1;
         m_pc        = RESET_PC;
         m_stale     = 1'b0;
         m_stale_addr = RESET_PC;
         q_skid.delete();
         modelBubble();
         m_stall_cnt = 32'd0;
         m_flush_cnt = 32'd0;
      end else begin
         if (stall && (m_stall_cnt != 32'hFFFF_FFFF)) m_stall_cnt++;
         if (flush && (m_flush_cnt != 32'hFFFF_FFFF)) m_flush_cnt++;
         if (flush) begin
            modelBubble();
            q_skid.delete();
            if (req_now && !ack_eff) begin
               if (!m_stale) m_stale_addr = m_pc;
               m_stale = 1'b1;
            end else begin
               m_stale = 1'b0;
            end
            m_pc = redir & 32'hFFFF_FFFC;
         end else if (m_stale) begin
            if (ack_eff) m_stale = 1'b0;
            if (!stall) modelBubble();
         end else if (q_skid.size() != 0) begin
            if (!stall) begin
               {m_inst, m_pc4} = q_skid.pop_front();
               m_valid = 1'b1;
               m_pc    = m_pc + 32'd4;
            end
         end else if (ack_eff) begin
            if (stall) begin
               q_skid.push_back({mem_word(addr_now), m_pc + 32'd4});
            end else begin
               m_inst  = mem_word(addr_now);
               m_pc4   = m_pc + 32'd4;
               m_valid = 1'b1;
               m_pc    = m_pc + 32'd4;
            end
         end else if (!stall) begin
            modelBubble();
         end
         m_in_reset = 1'b0;
      end
      @(negedge clk_i);
      if (m_started) checkModel();
   endtask

   initial begin
      rst_i         = 1'b1;
      stall_i       = 1'b0;
      flush_i       = 1'b0;
      redirect_pc_i = 32'd0;
      imem_ack_i    = 1'b0;
      imem_data_i   = 32'd0;
      m_in_reset    = 1'b1;
      m_pc          = RESET_PC;
      m_stale       = 1'b0;
      m_stale_addr  = RESET_PC;
      m_inst        = NOP_INST;
      m_pc4         = 32'd0;
      m_valid       = 1'b0;
      m_stall_cnt   = 32'd0;
      m_flush_cnt   = 32'd0;
      @(negedge clk_i);

      // Reset state
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("rst_req", 32'(imem_req_o), 32'd0);
      checkOutput("rst_valid", 32'(ifid_valid_o), 32'd0);
      checkOutput("rst_inst", ifid_inst_o, NOP_INST);
      checkOutput("rst_pc4", ifid_pc4_o, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("first_req", 32'(imem_req_o), 32'd1);
      checkOutput("first_addr", imem_addr_o, 32'd0);

      // Zero-wait stream
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
         checkOutput("zw_pc4", ifid_pc4_o, 32'(4 * k));
         checkOutput("zw_inst", ifid_inst_o, 32'(4 * k - 4) ^ 32'hA5A5_0000);
         checkOutput("zw_valid", 32'(ifid_valid_o), 32'd1);
      end

      // Two-cycle latency memory
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
         checkOutput("lat_bubble", 32'(ifid_valid_o), 32'd0);
         applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
         checkOutput("lat_valid", 32'(ifid_valid_o), 32'd1);
         checkOutput("lat_pc4", ifid_pc4_o, 32'(16 + 4 * k + 4));
      end

      // Load-use stall with the fetch of 0x10 landing in the skid buffer
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0C, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("lu_req", 32'(imem_req_o), 32'd0);
      checkOutput("lu_hold_pc4", ifid_pc4_o, 32'h10);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      checkOutput("lu_hold_pc4b", ifid_pc4_o, 32'h10);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("lu_inst", ifid_inst_o, 32'h10 ^ 32'hA5A5_0000);
      checkOutput("lu_pc4", ifid_pc4_o, 32'h14);
      checkOutput("lu_next", imem_addr_o, 32'h14);

      // Flush while a request is waiting
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
      checkOutput("fw_busy", 32'(fetch_busy_o), 32'd1);
      checkOutput("fw_addr", imem_addr_o, 32'h20);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("fw_addr2", imem_addr_o, 32'h20);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("fw_redir", imem_addr_o, 32'h100);
      checkOutput("fw_novalid", 32'(ifid_valid_o), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("fw_pc4", ifid_pc4_o, 32'h104);

      // Flush and stall together while parked in the skid buffer
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("fs_busy", 32'(fetch_busy_o), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h43, 1'b0);
      checkOutput("fs_valid", 32'(ifid_valid_o), 32'd0);
      checkOutput("fs_addr", imem_addr_o, 32'h40);

      // Reset in the middle of a wait, ack arriving during reset
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h30, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      checkOutput("rw_addr", imem_addr_o, 32'h30);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("rw_valid", 32'(ifid_valid_o), 32'd0);
      checkOutput("rw_req", 32'(imem_req_o), 32'd0);
`ifdef IF_PERF_CNT_EN
      checkOutput("rw_stall_cnt", stall_cnt_o, 32'd0);
      checkOutput("rw_flush_cnt", flush_cnt_o, 32'd0);
`endif
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("rw_addr0", imem_addr_o, RESET_PC);

      // PC wrap at the top of the address space
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("wrap_pc4", ifid_pc4_o, 32'd0);
      checkOutput("wrap_addr", imem_addr_o, 32'd0);

      // Random traffic
      repeat (600) begin
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 7) == 0, $urandom(), $urandom_range(0, 1) == 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
